cmp_filter: RTL and testbench
=============================

# cmp_filter

Complementary filter for the attitude-estimation path. Each enabled cycle it blends gyro-integrated pitch/roll angles with accelerometer-derived pitch/roll angles using a fixed weight ALPHA/128. Yaw has no accelerometer reference and is passed through from the gyro. It sits between the gyro integrator / accelerometer angle stages and the PID attitude controller.

## Interface
- ALPHA, default 99: gyro weight in 1/128 units. Accelerometer weight is 128-ALPHA. Legal range 0..128; any other value is an elaboration-time error.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-high (asserted = 1); clears all outputs immediately. The port name follows the codebase, but the polarity is high.
- cmp_filter_en  input  1  update strobe; outputs update only on cycles where it is sampled 1.
- cur_pitch_gyro  input  24  gyro pitch angle, two's-complement signed.
- cur_roll_gyro  input  24  gyro roll angle, signed.
- cur_yaw_gyro  input  24  gyro yaw angle, signed.
- cur_pitch_acc  input  24  accelerometer pitch angle, signed.
- cur_roll_acc  input  24  accelerometer roll angle, signed.
- cur_pitch  output  24  filtered pitch, signed, registered.
- cur_roll  output  24  filtered roll, signed, registered.
- cur_yaw  output  24  yaw, signed, registered copy of cur_yaw_gyro.

## Operation
- On a rising clk edge with cmp_filter_en = 1:
  - cur_pitch <= (ALPHA*cur_pitch_gyro + (128-ALPHA)*cur_pitch_acc) >>> 7.
  - cur_roll <= the same formula applied to the roll inputs.
  - cur_yaw <= cur_yaw_gyro.
- With cmp_filter_en = 0, all outputs hold their values.
- Arithmetic is signed throughout:
  - Inputs are sign-extended.
  - Each product is held in at least 32 bits; the sum in at least 33 bits.
  - The shift is arithmetic and rounds toward −inf.
  - The result is truncated to 24 bits. It cannot overflow, because it is a convex combination of two 24-bit values.
- ALPHA = 128: the output equals the gyro input. ALPHA = 0: the output equals the accelerometer input.
- Pitch and roll paths are independent and identical. No state is carried between updates (no feedback term).

## Timing
- Reset (rst_n = 1, asynchronous): cur_pitch = cur_roll = cur_yaw = 0. They remain 0 until the first enabled edge after release.
- Latency: 1 clk. Inputs sampled at edge N with en = 1 appear on the outputs after edge N and are stable until the next enabled edge.
- Holding en = 1 continuously gives one new result per cycle (full throughput). No handshake and no busy state.
- Reset asserted mid-stream: outputs clear immediately. The first enabled edge after release produces a fresh result.

## Configuration
- CMP_FILTER_ROUND_EN:
  - When defined, 64 is added to the sum before the >>> 7, giving round-half-up.
  - When undefined, the result is a plain arithmetic shift (floor).
  - Yaw is unaffected either way.

## Test plan
- Reset: hold rst_n = 1 with inputs nonzero, toggling en -> all outputs 0. Asserting rst_n between clock edges clears the outputs without a clock edge.
- Nominal blend, ALPHA = 99, en = 1, one cycle:
  - Inputs: pitch_gyro = 9900, pitch_acc = 10000, roll_gyro = 4950, roll_acc = 5000, yaw_gyro = 1234.
  - Required after the next edge: pitch = 9922, roll = 4961, yaw = 1234.
  - With CMP_FILTER_ROUND_EN: pitch = 9923, roll = 4961.
- Hold: after the nominal case, drop en and change all inputs -> outputs stay at 9922 / 4961 / 1234.
- Negative values, ALPHA = 99:
  - gyro = −1000, acc = −1000 -> −1000.
  - gyro = 0, acc = −128 -> −29.
  - gyro = 0, acc = −1 -> −1 (floor); 0 with CMP_FILTER_ROUND_EN.
- Weight extremes, gyro = 500, acc = −700: ALPHA = 128 -> 500; ALPHA = 0 -> −700.
- Throughput: en held high with inputs changing every cycle -> each output equals the formula applied to the previous cycle's inputs, with no gaps.

Source files
------------

// File: rtl/cmp_filter.sv
// cmp_filter: complementary pitch/roll blend with gyro weight ALPHA/128, yaw passthrough.
// Define CMP_FILTER_ROUND_EN for round-half-up instead of floor.
module cmp_filter #(
  parameter int ALPHA = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmp_filter_en,
  input  logic [23:0] cur_pitch_gyro,
  input  logic [23:0] cur_roll_gyro,
  input  logic [23:0] cur_yaw_gyro,
  input  logic [23:0] cur_pitch_acc,
  input  logic [23:0] cur_roll_acc,
  output logic [23:0] cur_pitch,
  output logic [23:0] cur_roll,
  output logic [23:0] cur_yaw
);
  if (ALPHA < 0 || ALPHA > 128) begin : g_alpha_chk
    $error("cmp_filter: ALPHA must be in 0..128");
  end
  localparam logic signed [32:0] WG = 33'(ALPHA);
  localparam logic signed [32:0] WA = 33'(128 - ALPHA);
  // Convex combination of two 24-bit values, so truncation back to 24 bits is lossless.
  function automatic logic [23:0] blend(input logic signed [23:0] g, input logic signed [23:0] a);
    logic signed [32:0] s;
`ifdef CMP_FILTER_ROUND_EN
    s = WG * 33'(g) + WA * 33'(a) + 33'sd64;
`else
    s = WG * 33'(g) + WA * 33'(a);
`endif
    return 24'(s >>> 7);
  endfunction
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      cur_pitch <= '0;
      cur_roll  <= '0;
      cur_yaw   <= '0;
    end else if (cmp_filter_en) begin
      cur_pitch <= blend(cur_pitch_gyro, cur_pitch_acc);
      cur_roll  <= blend(cur_roll_gyro, cur_roll_acc);
      cur_yaw   <= cur_yaw_gyro;
    end
endmodule

// File: tb/tb_cmp_filter.sv
// tb_cmp_filter: randomized and directed checks of cmp_filter at ALPHA = 99, 128 and 0.
module tb_cmp_filter;
  logic clk = 0;
  logic rst_n = 1;
  logic en = 0;
  logic signed [23:0] pg = 0, rg = 0, yg = 0, pa = 0, ra = 0;
  logic [23:0] p99, r99, y99, p128, r128, y128, p0, r0, y0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cmp_filter #(.ALPHA(99)) dut99 (.clk(clk), .rst_n(rst_n), .cmp_filter_en(en),
    .cur_pitch_gyro(pg), .cur_roll_gyro(rg), .cur_yaw_gyro(yg), .cur_pitch_acc(pa), .cur_roll_acc(ra),
    .cur_pitch(p99), .cur_roll(r99), .cur_yaw(y99));
  cmp_filter #(.ALPHA(128)) dut128 (.clk(clk), .rst_n(rst_n), .cmp_filter_en(en),
    .cur_pitch_gyro(pg), .cur_roll_gyro(rg), .cur_yaw_gyro(yg), .cur_pitch_acc(pa), .cur_roll_acc(ra),
    .cur_pitch(p128), .cur_roll(r128), .cur_yaw(y128));
  cmp_filter #(.ALPHA(0)) dut0 (.clk(clk), .rst_n(rst_n), .cmp_filter_en(en),
    .cur_pitch_gyro(pg), .cur_roll_gyro(rg), .cur_yaw_gyro(yg), .cur_pitch_acc(pa), .cur_roll_acc(ra),
    .cur_pitch(p0), .cur_roll(r0), .cur_yaw(y0));

  // Reference: weighted average divided by 128, rounded toward -inf (or half-up).
  function automatic logic [23:0] ref_blend(input int a, input logic signed [23:0] g, input logic signed [23:0] c);
    longint n, q;
    n = longint'(a) * longint'(g) + longint'(128 - a) * longint'(c);
`ifdef CMP_FILTER_ROUND_EN
    n = n + 64;
`endif
    q = n / 128;
    if (n % 128 != 0 && n < 0) q = q - 1;
    return 24'(q);
  endfunction

  function automatic logic signed [23:0] rnd24();
    return 24'($urandom);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1; pg = 111; rg = 222; yg = 333; pa = 444; ra = 555;
    for (int i = 0; i < 4; i++) begin
      en = i[0];
      step();
      tests++;
      if ({p99, r99, y99, p128, r128, y128, p0, r0, y0} !== '0) begin
        fails++;
        $display("FAIL reset_hold cyc %0d: got p=%0d r=%0d y=%0d, want 0", i, $signed(p99), $signed(r99), $signed(y99));
      end
    end
    @(negedge clk);
    rst_n = 0; en = 1;
    step();
    tests++;
    if (p99 !== ref_blend(99, pg, pa) || y99 !== 24'(yg)) begin
      fails++;
      $display("FAIL reset_release: got p=%0d y=%0d, want p=%0d y=%0d", $signed(p99), $signed(y99), $signed(ref_blend(99, pg, pa)), yg);
    end
    #2 rst_n = 1;
    #1;
    tests++;
    if ({p99, r99, y99, p128, r128, y128, p0, r0, y0} !== '0) begin
      fails++;
      $display("FAIL reset_async: got p=%0d r=%0d y=%0d, want 0", $signed(p99), $signed(r99), $signed(y99));
    end
    @(negedge clk);
    rst_n = 0;
  endtask

  task automatic test_nominal();
    logic signed [23:0] ep;
`ifdef CMP_FILTER_ROUND_EN
    ep = 9923;
`else
    ep = 9922;
`endif
    @(negedge clk);
    en = 1; pg = 9900; pa = 10000; rg = 4950; ra = 5000; yg = 1234;
    step();
    tests++;
    if (p99 !== ep || r99 !== 24'd4961 || y99 !== 24'd1234) begin
      fails++;
      $display("FAIL nominal: got %0d/%0d/%0d, want %0d/4961/1234", $signed(p99), $signed(r99), $signed(y99), ep);
    end
  endtask

  task automatic test_hold();
    logic [23:0] hp, hr, hy;
    hp = ref_blend(99, pg, pa); hr = ref_blend(99, rg, ra); hy = yg;
    @(negedge clk);
    en = 0;
    for (int i = 0; i < 3; i++) begin
      pg = rnd24(); rg = rnd24(); yg = rnd24(); pa = rnd24(); ra = rnd24();
      step();
      tests++;
      if (p99 !== hp || r99 !== hr || y99 !== hy) begin
        fails++;
        $display("FAIL hold cyc %0d: got %0d/%0d/%0d, want %0d/%0d/%0d", i, $signed(p99), $signed(r99), $signed(y99), $signed(hp), $signed(hr), $signed(hy));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_negative();
    logic signed [23:0] g [3] = '{-24'sd1000, 24'sd0, 24'sd0};
    logic signed [23:0] c [3] = '{-24'sd1000, -24'sd128, -24'sd1};
    logic signed [23:0] w [3];
`ifdef CMP_FILTER_ROUND_EN
    w = '{-24'sd1000, -24'sd29, 24'sd0};
`else
    w = '{-24'sd1000, -24'sd29, -24'sd1};
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1; pg = g[i]; pa = c[i]; rg = g[i]; ra = c[i];
      step();
      tests++;
      if (p99 !== w[i] || r99 !== w[i]) begin
        fails++;
        $display("FAIL negative %0d: got p=%0d r=%0d, want %0d", i, $signed(p99), $signed(r99), w[i]);
      end
    end
  endtask

  task automatic test_extremes();
    @(negedge clk);
    en = 1; pg = 500; pa = -700; rg = -700; ra = 500;
    step();
    tests++;
    if (p128 !== 24'd500 || r128 !== 24'(-700)) begin
      fails++;
      $display("FAIL alpha128: got p=%0d r=%0d, want 500/-700", $signed(p128), $signed(r128));
    end
    tests++;
    if (p0 !== 24'(-700) || r0 !== 24'd500) begin
      fails++;
      $display("FAIL alpha0: got p=%0d r=%0d, want -700/500", $signed(p0), $signed(r0));
    end
  endtask

  task automatic test_throughput();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      en = 1; pg = rnd24(); rg = rnd24(); yg = rnd24(); pa = rnd24(); ra = rnd24();
      if (i % 4 == 0) begin pg = pg >>> 8; pa = pa >>> 8; end
      step();
      tests++;
      if (p99 !== ref_blend(99, pg, pa) || r99 !== ref_blend(99, rg, ra) || y99 !== 24'(yg)) begin
        fails++;
        $display("FAIL throughput a99 cyc %0d: got %0d/%0d/%0d, want %0d/%0d/%0d", i, $signed(p99), $signed(r99), $signed(y99),
          $signed(ref_blend(99, pg, pa)), $signed(ref_blend(99, rg, ra)), yg);
      end
      tests++;
      if (p128 !== 24'(pg) || r128 !== 24'(rg) || p0 !== 24'(pa) || r0 !== 24'(ra)) begin
        fails++;
        $display("FAIL throughput extremes cyc %0d: got %0d/%0d/%0d/%0d, want %0d/%0d/%0d/%0d", i,
          $signed(p128), $signed(r128), $signed(p0), $signed(r0), pg, rg, pa, ra);
      end
    end
  endtask

  task automatic test_random_en();
    logic [23:0] ep, er, ey;
    ep = p99; er = r99; ey = y99;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      en = 1'($urandom); pg = rnd24(); rg = rnd24(); yg = rnd24(); pa = rnd24(); ra = rnd24();
      if (en) begin ep = ref_blend(99, pg, pa); er = ref_blend(99, rg, ra); ey = yg; end
      step();
      tests++;
      if (p99 !== ep || r99 !== er || y99 !== ey) begin
        fails++;
        $display("FAIL random_en cyc %0d en=%0b: got %0d/%0d/%0d, want %0d/%0d/%0d", i, en,
          $signed(p99), $signed(r99), $signed(y99), $signed(ep), $signed(er), $signed(ey));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_hold();
    test_negative();
    test_extremes();
    test_throughput();
    test_random_en();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
